// File: rtl/audio_pkg.sv
// Shared constants and elaboration-time helpers for the serial audio transmitter.
package audio_pkg;

    // Serial data alignment: I2S delays data one BCLK after the word-select edge.
    typedef enum logic {
        MODE_I2S = 1'b0,
        MODE_LJ  = 1'b1
    } tx_mode_e;

    // Saturation point of the underrun counter (8-bit status display).
    localparam int UNDERRUN_MAX = 255;

    // Number of BCLKs in one complete frame.
    function automatic int frame_bits(input int nch, input int slot_w);
        return nch * slot_w;
    endfunction

    // Ceiling log2; clog2(1) = 0. Bounded loop keeps it usable as a constant function.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO. Read data is registered and always reflects the head
// entry, with a write-through path so a frame pushed into the head slot is
// visible on the following cycle.
module audio_frame_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   level
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [WIDTH-1:0] rd_data_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W:0]   level_reg;
    logic [PTR_W:0]   level_next;
    logic             full_reg;
    logic             empty_reg;
    logic             push_ok;
    logic             pop_ok;
    logic             bypass;

    // Accept/pop qualification and next occupancy; pushes while full are dropped.
    always_comb begin
        push_ok     = push && !full_reg;
        pop_ok      = pop && !empty_reg;
        rd_ptr_next = pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        bypass      = push_ok && (wr_ptr_reg == rd_ptr_next);
        level_next  = level_reg;
        if (push_ok && !pop_ok) begin
            level_next = level_reg + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_next = level_reg - 1'b1;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok && !srst) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Registered read of the next head entry, forwarding a same-cycle write to it.
    always_ff @(posedge clk) begin
        rd_data_reg <= bypass ? push_data : mem[rd_ptr_next];
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            full_reg   <= (level_next == (PTR_W + 1)'(DEPTH));
            empty_reg  <= (level_next == '0);
        end
    end

    assign pop_data = rd_data_reg;
    assign full     = full_reg;
    assign empty    = empty_reg;
    assign level    = level_reg;

endmodule

// File: rtl/audio_tdm_tx.sv
// Serial audio transmitter: buffers PCM frames and emits BCLK, LRCK/frame-sync
// and MSB-first data in I2S, left-justified or TDM format.
module audio_tdm_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 16,
    parameter int NCH        = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_HALF  = 16
) (
    input  logic                        m_clock,
    input  logic                        p_reset,
    input  logic                        cfg_mode,
    input  logic                        cfg_mute,
    input  logic                        wr_en,
    input  logic [NCH*SAMPLE_W-1:0]     wr_data,
    output logic                        wr_full,
    output logic [clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [7:0]                  underrun_cnt,
    output logic                        aud_bclk,
    output logic                        aud_lrck,
    output logic                        aud_data
);

    localparam int FRAME_BITS = frame_bits(NCH, SLOT_W);
    localparam int FRAME_W    = NCH * SAMPLE_W;
    localparam int FBIT_W     = clog2(FRAME_BITS);
    localparam int DIV_W      = clog2(BCLK_HALF);
    localparam int PAD_W      = SLOT_W - SAMPLE_W;

    localparam logic [FBIT_W-1:0] FRAME_LAST = FBIT_W'(FRAME_BITS - 1);
    localparam logic [FBIT_W-1:0] SLOT_LEN   = FBIT_W'(SLOT_W);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCLK_HALF - 1);

    // Registered state
    logic [DIV_W-1:0]      div_cnt_reg;
    logic                  bclk_reg;
    logic                  lrck_reg;
    logic                  data_reg;
    logic                  lj_dly_reg;
    tx_mode_e              mode_reg;
    logic [FBIT_W-1:0]     fbit_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [7:0]            underrun_reg;

    // Next-state / combinational
    logic                  div_tc;
    logic                  fall_edge;
    logic                  wrap;
    logic [FBIT_W-1:0]     fbit_next;
    tx_mode_e              mode_next;
    logic [FRAME_BITS-1:0] load_frame;
    logic [FRAME_BITS-1:0] shift_src;
    logic [FRAME_BITS-1:0] shift_next;
    logic                  lj_bit;
    logic                  data_next;
    logic                  lrck_next;

    // FIFO interface
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [FRAME_W-1:0]    fifo_rd_data;
    logic [FRAME_BITS-1:0] pop_frame;

    audio_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (m_clock),
        .srst      (p_reset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (wr_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Spread the popped frame into slots: channel 0 (wr_data MSBs) goes first,
    // each sample MSB-aligned in its slot with zero padding below.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_slot
            logic [SLOT_W-1:0] slot_val;
            assign slot_val = SLOT_W'(fifo_rd_data[(NCH-gi)*SAMPLE_W-1 -: SAMPLE_W]) << PAD_W;
            assign pop_frame[FRAME_BITS-1-gi*SLOT_W -: SLOT_W] = slot_val;
        end
    endgenerate

    // Bit-clock timing, frame position and next serial/word-select values.
    always_comb begin
        div_tc    = (div_cnt_reg == DIV_LAST);
        fall_edge = div_tc && bclk_reg;
        wrap      = (fbit_reg == FRAME_LAST);
        fbit_next = wrap ? '0 : fbit_reg + 1'b1;
        mode_next = wrap ? tx_mode_e'(cfg_mode) : mode_reg;
        fifo_pop  = fall_edge && wrap && !fifo_empty;

        // Underrun or mute sends a silent frame; a muted frame still consumes the FIFO.
        if (fifo_empty || cfg_mute) begin
            load_frame = '0;
        end else begin
            load_frame = pop_frame;
        end

        shift_src  = wrap ? load_frame : shift_reg;
        lj_bit     = shift_src[FRAME_BITS-1];
        shift_next = shift_src << 1;
        data_next  = (mode_next == MODE_LJ) ? lj_bit : lj_dly_reg;

        // Stereo: level word select, polarity by mode. TDM: one-BCLK pulse at frame start.
        if (NCH == 2) begin
            if (fbit_next < SLOT_LEN) begin
                lrck_next = (mode_next == MODE_LJ);
            end else begin
                lrck_next = (mode_next == MODE_I2S);
            end
        end else begin
            lrck_next = (fbit_next == '0);
        end
    end

    // BCLK divider: toggle at the terminal count of each half period.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            div_cnt_reg <= '0;
            bclk_reg    <= 1'b0;
        end else if (div_tc) begin
            div_cnt_reg <= '0;
            bclk_reg    <= ~bclk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // Serializer: everything visible to the codec moves on BCLK falling edges only.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            fbit_reg     <= FRAME_LAST;
            mode_reg     <= MODE_I2S;
            shift_reg    <= '0;
            lj_dly_reg   <= 1'b0;
            data_reg     <= 1'b0;
            lrck_reg     <= 1'b0;
            underrun_reg <= '0;
        end else if (fall_edge) begin
            fbit_reg   <= fbit_next;
            mode_reg   <= mode_next;
            shift_reg  <= shift_next;
            lj_dly_reg <= lj_bit;
            data_reg   <= data_next;
            lrck_reg   <= lrck_next;
            if (wrap && fifo_empty && (underrun_reg != 8'(UNDERRUN_MAX))) begin
                underrun_reg <= underrun_reg + 8'd1;
            end
        end
    end

    assign aud_bclk     = bclk_reg;
    assign aud_lrck     = lrck_reg;
    assign aud_data     = data_reg;
    assign underrun_cnt = underrun_reg;

endmodule

// File: tb/tb_audio_tdm_tx.sv
// Directed/randomized bench for audio_tdm_tx. A behavioural model derives every
// expected output from elapsed clock counts, a frame queue and slot arithmetic.
module tb_audio_tdm_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Bench drive
    logic         p_reset_drv = 1'b1;
    logic         cfg_mode    = 1'b0;
    logic         cfg_mute    = 1'b0;
    logic         wr_en_drv   = 1'b0;
    logic [127:0] wr_data_drv = '0;
    int           sel         = 0;

    // Per-instance wiring; unselected instances are held in reset.
    logic rst_a, rst_b, rst_c, we_a, we_b, we_c;
    logic a_full, b_full, c_full;
    logic [2:0] a_level, b_level, c_level;
    logic [7:0] a_under, b_under, c_under;
    logic a_bclk, b_bclk, c_bclk, a_lrck, b_lrck, c_lrck, a_data, b_data, c_data;

    assign rst_a = (sel == 0) ? p_reset_drv : 1'b1;
    assign rst_b = (sel == 1) ? p_reset_drv : 1'b1;
    assign rst_c = (sel == 2) ? p_reset_drv : 1'b1;
    assign we_a  = (sel == 0) && wr_en_drv;
    assign we_b  = (sel == 1) && wr_en_drv;
    assign we_c  = (sel == 2) && wr_en_drv;

    // Default stereo format, 32 m_clock BCLK period
    audio_tdm_tx dut_a (
        .m_clock(clk), .p_reset(rst_a), .cfg_mode(cfg_mode), .cfg_mute(cfg_mute),
        .wr_en(we_a), .wr_data(wr_data_drv[31:0]), .wr_full(a_full),
        .fifo_level(a_level), .underrun_cnt(a_under),
        .aud_bclk(a_bclk), .aud_lrck(a_lrck), .aud_data(a_data)
    );

    // Stereo with a fast BCLK for long underrun runs
    audio_tdm_tx #(.BCLK_HALF(2)) dut_b (
        .m_clock(clk), .p_reset(rst_b), .cfg_mode(cfg_mode), .cfg_mute(cfg_mute),
        .wr_en(we_b), .wr_data(wr_data_drv[31:0]), .wr_full(b_full),
        .fifo_level(b_level), .underrun_cnt(b_under),
        .aud_bclk(b_bclk), .aud_lrck(b_lrck), .aud_data(b_data)
    );

    // 4-channel TDM, 24-bit samples in 32-bit slots
    audio_tdm_tx #(.SAMPLE_W(24), .SLOT_W(32), .NCH(4), .BCLK_HALF(2)) dut_c (
        .m_clock(clk), .p_reset(rst_c), .cfg_mode(cfg_mode), .cfg_mute(cfg_mute),
        .wr_en(we_c), .wr_data(wr_data_drv[95:0]), .wr_full(c_full),
        .fifo_level(c_level), .underrun_cnt(c_under),
        .aud_bclk(c_bclk), .aud_lrck(c_lrck), .aud_data(c_data)
    );

    logic       obs_full, obs_bclk, obs_lrck, obs_data;
    logic [2:0] obs_level;
    logic [7:0] obs_under;

    always_comb begin
        obs_full = a_full; obs_level = a_level; obs_under = a_under;
        obs_bclk = a_bclk; obs_lrck = a_lrck; obs_data = a_data;
        if (sel == 1) begin
            obs_full = b_full; obs_level = b_level; obs_under = b_under;
            obs_bclk = b_bclk; obs_lrck = b_lrck; obs_data = b_data;
        end else if (sel == 2) begin
            obs_full = c_full; obs_level = c_level; obs_under = c_under;
            obs_bclk = c_bclk; obs_lrck = c_lrck; obs_data = c_data;
        end
    end

    // Scoreboard counters
    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int           m_t, m_nch, m_sw, m_slot, m_bh, m_depth, m_fb, m_under;
    logic [127:0] m_q[$];
    logic [127:0] m_frame;
    logic         m_mode, m_prev, m_fall;
    logic         e_data, e_lrck, e_bclk;
    logic [127:0] cap;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s sel=%0d t=%0d observed=%0h expected=%0h", tag, sel, m_t, obs, exp);
        end
    endtask

    // Frame bit layout from the sample words: slot by slot, MSB first, zero pad.
    function automatic logic [127:0] format_frame(input logic [127:0] f);
        logic [127:0] r;
        r = '0;
        for (int ch = 0; ch < m_nch; ch++) begin
            for (int i = 0; i < m_slot; i++) begin
                if (i < m_sw) begin
                    r[m_fb-1-ch*m_slot-i] = f[(m_nch-ch)*m_sw-1-i];
                end
            end
        end
        return r;
    endfunction

    // One m_clock edge of the behavioural model, using inputs present at that edge.
    task automatic model_step();
        int   j, b;
        logic pre_full, pre_empty, lj;
        logic [127:0] f;
        m_fall = 1'b0;
        if (p_reset_drv) begin
            m_t = 0; m_q.delete(); m_frame = '0; m_under = 0;
            m_mode = 1'b0; m_prev = 1'b0;
            e_data = 1'b0; e_lrck = 1'b0; e_bclk = 1'b0;
            return;
        end
        m_t++;
        e_bclk    = ((m_t / m_bh) % 2) == 1;
        pre_full  = (m_q.size() == m_depth);
        pre_empty = (m_q.size() == 0);
        if ((m_t % (2 * m_bh)) == 0) begin
            m_fall = 1'b1;
            j = m_t / (2 * m_bh);
            b = (j - 1) % m_fb;
            if (b == 0) begin
                m_mode = cfg_mode;
                if (!pre_empty) begin
                    f = m_q.pop_front();
                    m_frame = cfg_mute ? '0 : format_frame(f);
                end else begin
                    m_frame = '0;
                    if (m_under < 255) m_under++;
                end
            end
            lj     = m_frame[m_fb-1-b];
            e_data = m_mode ? lj : m_prev;
            m_prev = lj;
            if (m_nch == 2) e_lrck = m_mode ? (b < m_slot) : (b >= m_slot);
            else            e_lrck = (b == 0);
        end
        if (wr_en_drv && !pre_full) m_q.push_back(wr_data_drv);
    endtask

    task automatic compare_all();
        chk("bclk",  128'(obs_bclk),  128'(e_bclk));
        chk("data",  128'(obs_data),  128'(e_data));
        chk("lrck",  128'(obs_lrck),  128'(e_lrck));
        chk("level", 128'(obs_level), 128'(m_q.size()));
        chk("full",  128'(obs_full),  128'(m_q.size() == m_depth));
        chk("under", 128'(obs_under), 128'(m_under));
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
            if (m_fall) cap = {cap[126:0], obs_data};
        end
    endtask

    task automatic run_to(input int target);
        if (target > m_t) tick(target - m_t);
    endtask

    task automatic push(input logic [127:0] d);
        wr_en_drv   = 1'b1;
        wr_data_drv = d;
        $display("push sel=%0d t=%0d data=%0h", sel, m_t, d);
        tick(1);
        wr_en_drv = 1'b0;
    endtask

    task automatic select_dut(input int s);
        p_reset_drv = 1'b1;
        sel = s;
        m_nch = 2; m_sw = 16; m_slot = 16; m_bh = 16; m_depth = 4;
        if (s == 1) m_bh = 2;
        if (s == 2) begin m_nch = 4; m_sw = 24; m_slot = 32; m_bh = 2; end
        m_fb = m_nch * m_slot;
    endtask

    task automatic do_reset();
        p_reset_drv = 1'b1;
        tick(3);
        p_reset_drv = 1'b0;
        cap = '0;
    endtask

    initial begin
        cap = '0;
        // Left-justified, frame present before the first wrap
        select_dut(0);
        cfg_mode = 1'b1;
        do_reset();
        push(128'h A5A5_3C3C);
        run_to(1024);
        chk("lj_frame", cap[31:0], 128'h A5A5_3C3C);
        chk("lj_under0", 128'(obs_under), 128'd0);

        // I2S, frame arrives after an initial empty frame
        cfg_mode = 1'b0;
        do_reset();
        run_to(40);
        push(128'h A5A5_3C3C);
        run_to(2079);
        chk("i2s_under1", 128'(obs_under), 128'd1);
        run_to(2080);
        chk("i2s_frame", cap[31:0], 128'h A5A5_3C3C);

        // FIFO boundary: writes held across the first wrap while full
        cfg_mode = 1'b1;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            push(128'($urandom));
            if (m_t == 31) begin
                chk("full_lvl4", 128'(obs_level), 128'd4);
                chk("full_flag", 128'(obs_full), 128'd1);
            end
        end
        chk("wrap_lvl3", 128'(obs_level), 128'd3);
        run_to(6 * 1024 + 64);

        // Mute raised mid-frame, then reset mid-slot
        do_reset();
        push(128'($urandom));
        push(128'($urandom));
        run_to(512);
        cfg_mute = 1'b1;
        run_to(1064);
        chk("mute_lvl0", 128'(obs_level), 128'd0);
        run_to(2048);
        chk("mute_zero", cap[31:0], 128'd0);
        cfg_mute = 1'b0;
        push(128'($urandom));
        run_to(2600);
        p_reset_drv = 1'b1;
        tick(1);
        chk("rst_data", 128'(obs_data), 128'd0);
        chk("rst_lrck", 128'(obs_lrck), 128'd0);
        chk("rst_level", 128'(obs_level), 128'd0);
        p_reset_drv = 1'b0;
        tick(40);

        // Long underrun: counter saturates, then clean frames resume
        select_dut(1);
        cfg_mode = 1'b1;
        do_reset();
        run_to(300 * 128);
        chk("under_sat", 128'(obs_under), 128'd255);
        for (int i = 0; i < 4; i++) push(128'($urandom));
        run_to(m_t + 5 * 128);
        chk("under_hold", 128'(obs_under), 128'd255);

        // TDM: I2S then a mid-frame switch to left-justified
        select_dut(2);
        cfg_mode = 1'b0;
        do_reset();
        push({32'd0, $urandom, $urandom, $urandom});
        push({32'd0, $urandom, $urandom, $urandom});
        run_to(3 * 512 + 200);
        cfg_mode = 1'b1;
        push({32'd0, $urandom, $urandom, $urandom});
        run_to(6 * 512 + 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
